bank_write_arbiter: RTL and testbench
=====================================

Name: bank_write_arbiter

Overview:
Shares the 15 line-bank block RAMs (320x16 pixels each, 12-bit RGB) between two pixel producers: req0, the pattern/Mandelbrot generator, and req1, the UART memory loader. It accepts (x,y,data) pixel writes over valid/ready handshakes and arbitrates round-robin. It decodes y into bank select and local address, then drives the shared port-A address/data bus plus a one-hot per-bank write enable. It also tracks per-bank fill status and end-of-frame.

Parameters:
NUM_BANKS, 15, number of line-bank RAMs
LINES_PER_BANK, 16, rows per bank (power of two, fixed shift)
H_PIXELS, 320, pixels per row
V_PIXELS, 240, rows per frame
ADDR_WIDTH, 13, bank-local address width (covers 0..5119)
DATA_WIDTH, 12, pixel width
X_WIDTH, 9, x coordinate width
Y_WIDTH, 8, y coordinate width

Ports:
clk  in  1  system clock (100 MHz domain of the RAM write ports)
reset  in  1  asynchronous, active-high reset
i_enable  in  1  clock-enable strobe; grants occur only in cycles where it is high
i_req0_valid  in  1  requester 0 write request
i_req0_x  in  X_WIDTH  requester 0 column
i_req0_y  in  Y_WIDTH  requester 0 row
i_req0_data  in  DATA_WIDTH  requester 0 pixel
o_req0_ready  out  1  requester 0 accepted this cycle
i_req1_valid/x/y/data  in  1/X_WIDTH/Y_WIDTH/DATA_WIDTH  requester 1, same meaning
o_req1_ready  out  1  requester 1 accepted this cycle
o_wea  out  NUM_BANKS  one-hot bank write enable (registered)
o_addr  out  ADDR_WIDTH  shared bank-local write address (registered)
o_data  out  DATA_WIDTH  shared write data (registered)
i_clear  in  1  clears status bitmap, error flag and frame state
o_bank_full  out  NUM_BANKS  sticky: bank received its last pixel (x=319, row%16=15)
o_frame_done  out  1  one-cycle pulse when pixel (319,239) is written
o_err_range  out  1  sticky: an out-of-range request was accepted and dropped

Behaviour:
- Reset: o_wea=0, o_addr=0, o_data=0, o_req*_ready=0, o_bank_full=0, o_frame_done=0, o_err_range=0, rr pointer=0 (req0 favoured).
- ready is combinational from valid, i_enable and the rr pointer. Transfer occurs when valid&&ready. At most one ready is high per cycle.
- Arbitration:
  - If i_enable=0, no grant.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester the rr pointer favours. The pointer then flips to the other requester.
  - The pointer changes only on a grant made while both requesters are valid; a single-requester grant leaves it unchanged.
- Decode, pure shift-add, no divider:
  - bank = y[7:4]
  - local = (y[3:0]<<8) + (y[3:0]<<6) + x, computed at 13 bits, max 5119
- Latency: 1 cycle. A grant in cycle N gives o_wea[bank]=1, o_addr=local, o_data=data in cycle N+1. o_wea=0 in cycles with no grant. Full throughput: one write per enabled cycle.
- Range check: x>=H_PIXELS or y>=V_PIXELS means the request is still acknowledged (ready=1) but o_wea stays 0. o_err_range sets at N+1.
- o_bank_full[bank] sets in cycle N+1 for a write with x=319 and y[3:0]=15.
- o_frame_done pulses in cycle N+1 for a write to (319,239).
- i_clear:
  - Synchronous; zeroes o_bank_full, o_err_range and o_frame_done.
  - A write at N+1 coinciding with i_clear still reaches the RAM, but its status update is discarded (clear wins).
- Reset mid-transfer: the pending registered write is dropped, outputs go to reset values immediately, and the pointer returns to 0.
- Requester data is sampled only in the grant cycle. Requesters must hold x/y/data stable while valid=1 and ready=0.

Decomposition:
- Shared package: the frame constants H_PIXELS, V_PIXELS, LINES_PER_BANK and NUM_BANKS; the bank/local address width constants; and the pixel type of DATA_WIDTH bits. The VGA reader and the mux use the same package.
- One natural sub-module, rr_arbiter2: a two-requester round-robin arbiter with enable, outputting grant0/grant1. The decode and status logic stays in the parent.

Test Plan:
- req0 writes (0,0,0xABC) with i_enable=1 -> next cycle o_wea=15'h0001, o_addr=0, o_data=0xABC; o_req0_ready=1 in the grant cycle.
- req1 writes (319,239,0x123) -> o_wea[14]=1, o_addr=5119. One-cycle o_frame_done pulse; o_bank_full[14]=1.
- Both requesters valid for 4 cycles, i_enable=1 -> grants alternate 0,1,0,1. Exactly one ready high per cycle.
- i_enable toggling 1,0,1 with req0 held valid -> ready only in the enabled cycles; 2 writes total, and the data is held correctly across the stall.
- req0 at (320,5) and then (10,240) -> both acknowledged, o_wea stays 0, o_err_range=1. i_clear then returns it to 0.
- Assert reset in the cycle after a grant -> o_wea=0 immediately, o_bank_full=0, and the rr pointer favours req0 after release.

Source files
------------

// File: rtl/bank_write_arbiter_pkg.sv
// Frame geometry, bank/address widths and pixel type shared by the line-bank writers and readers.
// The decode helpers use shift-add only, so the row-to-address mapping stays divider free.
package bank_write_arbiter_pkg;

   localparam int NUM_BANKS      = 15;
   localparam int LINES_PER_BANK = 16;
   localparam int H_PIXELS       = 320;
   localparam int V_PIXELS       = 240;
   localparam int ADDR_WIDTH     = 13;
   localparam int DATA_WIDTH     = 12;
   localparam int X_WIDTH        = 9;
   localparam int Y_WIDTH        = 8;
   localparam int LINE_WIDTH     = $clog2(LINES_PER_BANK);
   localparam int BANK_WIDTH     = Y_WIDTH - LINE_WIDTH;

   typedef logic [DATA_WIDTH-1:0] pixel_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [BANK_WIDTH-1:0] bank_t;

   function automatic bank_t bank_of(input logic [Y_WIDTH-1:0] y);
      return y[Y_WIDTH-1:LINE_WIDTH];
   endfunction

   // line*320 + x, written as line*256 + line*64 + x
   function automatic addr_t local_addr(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
      addr_t line;
      line = addr_t'(y[LINE_WIDTH-1:0]);
      return (line << 8) + (line << 6) + addr_t'(x);
   endfunction

endpackage

// File: rtl/bank_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; grants are combinational, no grant while disabled or in reset.
// Pointer flips only when both requesters contend, so a lone requester never steals priority.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic i_enable,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_grant0,
   output logic o_grant1
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      o_grant0 = !reset && i_enable && i_req0 && (!i_req1 || !ptr_q);
      o_grant1 = !reset && i_enable && i_req1 && (!i_req0 ||  ptr_q);
      ptr_d    = ptr_q;
      if (i_enable && i_req0 && i_req1) begin
         ptr_d = !ptr_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bank_write_arbiter.sv
// Arbitrates two pixel writers onto the shared line-bank write port; 1-cycle registered write, full rate.
// Backpressure: ready is combinational, at most one requester accepted per enabled cycle.
module bank_write_arbiter
   import bank_write_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_enable,
   input  logic                  i_req0_valid,
   input  logic [X_WIDTH-1:0]    i_req0_x,
   input  logic [Y_WIDTH-1:0]    i_req0_y,
   input  logic [DATA_WIDTH-1:0] i_req0_data,
   output logic                  o_req0_ready,
   input  logic                  i_req1_valid,
   input  logic [X_WIDTH-1:0]    i_req1_x,
   input  logic [Y_WIDTH-1:0]    i_req1_y,
   input  logic [DATA_WIDTH-1:0] i_req1_data,
   output logic                  o_req1_ready,
   output logic [NUM_BANKS-1:0]  o_wea,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_clear,
   output logic [NUM_BANKS-1:0]  o_bank_full,
   output logic                  o_frame_done,
   output logic                  o_err_range
);

   logic gnt0;
   logic gnt1;

   rr_arbiter2 u_rr_arbiter2 (
      .clk      (clk),
      .reset    (reset),
      .i_enable (i_enable),
      .i_req0   (i_req0_valid),
      .i_req1   (i_req1_valid),
      .o_grant0 (gnt0),
      .o_grant1 (gnt1)
   );

   assign o_req0_ready = gnt0;
   assign o_req1_ready = gnt1;

   logic [X_WIDTH-1:0]   sel_x;
   logic [Y_WIDTH-1:0]   sel_y;
   pixel_t               sel_data;
   logic                 gnt;
   logic                 in_range;
   logic                 last_col;
   logic                 last_line;
   logic                 last_row;

   logic [NUM_BANKS-1:0] wea_q, wea_d;
   addr_t                addr_q, addr_d;
   pixel_t               data_q, data_d;
   logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
   logic                 frame_done_q, frame_done_d;
   logic                 err_range_q, err_range_d;

   always_comb begin
      sel_x     = gnt1 ? i_req1_x    : i_req0_x;
      sel_y     = gnt1 ? i_req1_y    : i_req0_y;
      sel_data  = gnt1 ? i_req1_data : i_req0_data;
      gnt       = gnt0 || gnt1;
      in_range  = (sel_x < X_WIDTH'(H_PIXELS)) && (sel_y < Y_WIDTH'(V_PIXELS));
      last_col  = (sel_x == X_WIDTH'(H_PIXELS - 1));
      last_line = (sel_y[LINE_WIDTH-1:0] == {LINE_WIDTH{1'b1}});
      last_row  = (sel_y == Y_WIDTH'(V_PIXELS - 1));

      wea_d  = '0;
      addr_d = addr_q;
      data_d = data_q;
      if (gnt) begin
         addr_d = local_addr(sel_x, sel_y);
         data_d = sel_data;
         if (in_range) begin
            wea_d = NUM_BANKS'(1) << bank_of(sel_y);
         end
      end

      // Status tracks the write being issued; a clear in the same cycle overrides it.
      bank_full_d  = bank_full_q;
      if (gnt && in_range && last_col && last_line) begin
         bank_full_d = bank_full_q | wea_d;
      end
      frame_done_d = gnt && in_range && last_col && last_row;
      err_range_d  = err_range_q || (gnt && !in_range);
      if (i_clear) begin
         bank_full_d  = '0;
         frame_done_d = 1'b0;
         err_range_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wea_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         bank_full_q  <= '0;
         frame_done_q <= 1'b0;
         err_range_q  <= 1'b0;
      end else begin
         wea_q        <= wea_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         bank_full_q  <= bank_full_d;
         frame_done_q <= frame_done_d;
         err_range_q  <= err_range_d;
      end
   end

   assign o_wea        = wea_q;
   assign o_addr       = addr_q;
   assign o_data       = data_q;
   assign o_bank_full  = bank_full_q;
   assign o_frame_done = frame_done_q;
   assign o_err_range  = err_range_q;

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Directed vector table for the bank write arbiter plus a hand sequence for reset during a write.
module tb_bank_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_enable;
   logic        i_req0_valid;
   logic [8:0]  i_req0_x;
   logic [7:0]  i_req0_y;
   logic [11:0] i_req0_data;
   logic        o_req0_ready;
   logic        i_req1_valid;
   logic [8:0]  i_req1_x;
   logic [7:0]  i_req1_y;
   logic [11:0] i_req1_data;
   logic        o_req1_ready;
   logic [14:0] o_wea;
   logic [12:0] o_addr;
   logic [11:0] o_data;
   logic        i_clear;
   logic [14:0] o_bank_full;
   logic        o_frame_done;
   logic        o_err_range;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bank_write_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .i_enable     (i_enable),
      .i_req0_valid (i_req0_valid),
      .i_req0_x     (i_req0_x),
      .i_req0_y     (i_req0_y),
      .i_req0_data  (i_req0_data),
      .o_req0_ready (o_req0_ready),
      .i_req1_valid (i_req1_valid),
      .i_req1_x     (i_req1_x),
      .i_req1_y     (i_req1_y),
      .i_req1_data  (i_req1_data),
      .o_req1_ready (o_req1_ready),
      .o_wea        (o_wea),
      .o_addr       (o_addr),
      .o_data       (o_data),
      .i_clear      (i_clear),
      .o_bank_full  (o_bank_full),
      .o_frame_done (o_frame_done),
      .o_err_range  (o_err_range)
   );

   typedef struct {
      logic        en;
      logic        clr;
      logic        v0;
      logic [8:0]  x0;
      logic [7:0]  y0;
      logic [11:0] d0;
      logic        v1;
      logic [8:0]  x1;
      logic [7:0]  y1;
      logic [11:0] d1;
      logic        r0;
      logic        r1;
      logic [14:0] wea;
      logic        chk_ad;
      logic [12:0] addr;
      logic [11:0] data;
      logic [14:0] full;
      logic        done;
      logic        err;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_enable     = 1'b0;
      i_clear      = 1'b0;
      i_req0_valid = 1'b0;
      i_req0_x     = '0;
      i_req0_y     = '0;
      i_req0_data  = '0;
      i_req1_valid = 1'b0;
      i_req1_x     = '0;
      i_req1_y     = '0;
      i_req1_data  = '0;
   endtask

   initial begin
      //           en    clr   v0    x0       y0      d0         v1    x1       y1      d1         r0    r1    wea         chk   addr       data       full        done  err
      vec[0]  = '{1'b1, 1'b0, 1'b1, 9'd0,   8'd0,   12'hABC, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd0,    12'hABC, 15'h0000, 1'b0, 1'b0};
      vec[1]  = '{1'b1, 1'b0, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 9'd319, 8'd239, 12'h123, 1'b0, 1'b1, 15'h4000, 1'b1, 13'd5119, 12'h123, 15'h4000, 1'b1, 1'b0};
      vec[2]  = '{1'b1, 1'b0, 1'b1, 9'd1,   8'd0,   12'h111, 1'b1, 9'd2,   8'd16,  12'h222, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd1,    12'h111, 15'h4000, 1'b0, 1'b0};
      vec[3]  = '{1'b1, 1'b0, 1'b1, 9'd1,   8'd0,   12'h111, 1'b1, 9'd2,   8'd16,  12'h222, 1'b0, 1'b1, 15'h0002, 1'b1, 13'd2,    12'h222, 15'h4000, 1'b0, 1'b0};
      vec[4]  = '{1'b1, 1'b0, 1'b1, 9'd1,   8'd0,   12'h111, 1'b1, 9'd2,   8'd16,  12'h222, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd1,    12'h111, 15'h4000, 1'b0, 1'b0};
      vec[5]  = '{1'b1, 1'b0, 1'b1, 9'd1,   8'd0,   12'h111, 1'b1, 9'd2,   8'd16,  12'h222, 1'b0, 1'b1, 15'h0002, 1'b1, 13'd2,    12'h222, 15'h4000, 1'b0, 1'b0};
      vec[6]  = '{1'b1, 1'b0, 1'b1, 9'd4,   8'd3,   12'h444, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd964,  12'h444, 15'h4000, 1'b0, 1'b0};
      vec[7]  = '{1'b0, 1'b0, 1'b1, 9'd5,   8'd3,   12'h555, 1'b0, 9'd0,   8'd0,   12'h000, 1'b0, 1'b0, 15'h0000, 1'b0, 13'd0,    12'h000, 15'h4000, 1'b0, 1'b0};
      vec[8]  = '{1'b1, 1'b0, 1'b1, 9'd5,   8'd3,   12'h555, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd965,  12'h555, 15'h4000, 1'b0, 1'b0};
      vec[9]  = '{1'b1, 1'b0, 1'b1, 9'd320, 8'd5,   12'h666, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0000, 1'b0, 13'd0,    12'h000, 15'h4000, 1'b0, 1'b1};
      vec[10] = '{1'b1, 1'b0, 1'b1, 9'd10,  8'd240, 12'h777, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0000, 1'b0, 13'd0,    12'h000, 15'h4000, 1'b0, 1'b1};
      vec[11] = '{1'b1, 1'b1, 1'b0, 9'd0,   8'd0,   12'h000, 1'b0, 9'd0,   8'd0,   12'h000, 1'b0, 1'b0, 15'h0000, 1'b0, 13'd0,    12'h000, 15'h0000, 1'b0, 1'b0};
      vec[12] = '{1'b1, 1'b1, 1'b1, 9'd319, 8'd15,  12'h0F0, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd5119, 12'h0F0, 15'h0000, 1'b0, 1'b0};
      vec[13] = '{1'b1, 1'b0, 1'b1, 9'd319, 8'd15,  12'h0F0, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd5119, 12'h0F0, 15'h0001, 1'b0, 1'b0};
      vec[14] = '{1'b1, 1'b0, 1'b0, 9'd0,   8'd0,   12'h000, 1'b1, 9'd0,   8'd32,  12'h0AA, 1'b0, 1'b1, 15'h0004, 1'b1, 13'd0,    12'h0AA, 15'h0001, 1'b0, 1'b0};
      vec[15] = '{1'b1, 1'b0, 1'b1, 9'd7,   8'd0,   12'h007, 1'b1, 9'd0,   8'd32,  12'h0AA, 1'b1, 1'b0, 15'h0001, 1'b1, 13'd7,    12'h007, 15'h0001, 1'b0, 1'b0};

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset wea",        32'(o_wea), 32'h0);
      check("reset addr",       32'(o_addr), 32'h0);
      check("reset data",       32'(o_data), 32'h0);
      check("reset bank_full",  32'(o_bank_full), 32'h0);
      check("reset frame_done", 32'(o_frame_done), 32'h0);
      check("reset err_range",  32'(o_err_range), 32'h0);
      i_enable     = 1'b1;
      i_req0_valid = 1'b1;
      #1;
      check("reset ready0", 32'(o_req0_ready), 32'h0);
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         i_enable     = vec[i].en;
         i_clear      = vec[i].clr;
         i_req0_valid = vec[i].v0;
         i_req0_x     = vec[i].x0;
         i_req0_y     = vec[i].y0;
         i_req0_data  = vec[i].d0;
         i_req1_valid = vec[i].v1;
         i_req1_x     = vec[i].x1;
         i_req1_y     = vec[i].y1;
         i_req1_data  = vec[i].d1;
         #1;
         check($sformatf("v%0d ready0", i), 32'(o_req0_ready), 32'(vec[i].r0));
         check($sformatf("v%0d ready1", i), 32'(o_req1_ready), 32'(vec[i].r1));
         @(posedge clk);
         #1;
         check($sformatf("v%0d wea", i), 32'(o_wea), 32'(vec[i].wea));
         if (vec[i].chk_ad) begin
            check($sformatf("v%0d addr", i), 32'(o_addr), 32'(vec[i].addr));
            check($sformatf("v%0d data", i), 32'(o_data), 32'(vec[i].data));
         end
         check($sformatf("v%0d bank_full", i),  32'(o_bank_full), 32'(vec[i].full));
         check($sformatf("v%0d frame_done", i), 32'(o_frame_done), 32'(vec[i].done));
         check($sformatf("v%0d err_range", i),  32'(o_err_range), 32'(vec[i].err));
      end

      // Pointer now favours req1; reset right after a grant must drop the write and restore req0 priority.
      @(negedge clk);
      idle_inputs();
      i_enable     = 1'b1;
      i_req0_valid = 1'b1;
      i_req0_x     = 9'd8;
      i_req0_data  = 12'h808;
      #1;
      check("rst seq ready0", 32'(o_req0_ready), 32'h1);
      @(posedge clk);
      #1;
      check("rst seq wea before", 32'(o_wea), 32'h1);
      #1;
      reset = 1'b1;
      #1;
      check("rst seq wea",       32'(o_wea), 32'h0);
      check("rst seq bank_full", 32'(o_bank_full), 32'h0);
      check("rst seq addr",      32'(o_addr), 32'h0);
      check("rst seq ready0 in reset", 32'(o_req0_ready), 32'h0);
      @(negedge clk);
      reset        = 1'b0;
      i_req1_valid = 1'b1;
      i_req1_y     = 8'd32;
      i_req1_data  = 12'h0AA;
      #1;
      check("post rst ready0", 32'(o_req0_ready), 32'h1);
      check("post rst ready1", 32'(o_req1_ready), 32'h0);
      @(posedge clk);
      #1;
      check("post rst wea",  32'(o_wea), 32'h1);
      check("post rst addr", 32'(o_addr), 32'd8);
      check("post rst data", 32'(o_data), 32'h808);
      @(negedge clk);
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
